// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared state type, counter width and index-width helper for the FP op arbiter
package fp_arb_pkg;

  // Arbiter sequencing: pick a requester, pulse the unit, wait for its result.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Width of the optional performance counters.
  localparam int PERF_CW = 32;

  // Bits needed to index n requesters; a single requester still gets one bit.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotate-priority encoder: first set request after 'last'
module rr_picker
  import fp_arb_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [IDW-1:0]  grant_idx
);

  // Walk offsets from farthest to nearest so the requester closest after 'last' wins.
  always_comb begin
    logic [IDW-1:0] idx;
    any       = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDW'((int'(last) + off) % NREQ);
      if (req[idx]) begin
        any       = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/fp_op_arbiter.sv
// rtl/fp_op_arbiter.sv - round-robin sharing of one non-pipelined FP unit; optional counters via FP_OP_ARBITER_PERF_CNT_EN
module fp_op_arbiter
  import fp_arb_pkg::*;
#(
  parameter int  DWIDTH = 64,
  parameter int  NREQ   = 4,
  localparam int IDW    = idw(NREQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][DWIDTH-1:0]   req_a,
  input  logic [NREQ-1:0][DWIDTH-1:0]   req_b,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREQ-1:0]               resp_finish,
  output logic [DWIDTH-1:0]             resp_result,
  output logic                          fu_valid,
  input  logic                          fu_ready,
  output logic [DWIDTH-1:0]             fu_a,
  output logic [DWIDTH-1:0]             fu_b,
  input  logic                          fu_finish,
  input  logic [DWIDTH-1:0]             fu_result,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id,
  output logic                          err_spurious
`ifdef FP_OP_ARBITER_PERF_CNT_EN
  ,
  output logic [NREQ-1:0][PERF_CW-1:0]  perf_grants,
  output logic [PERF_CW-1:0]            perf_busy_cycles
`endif
);

  state_t              state_q;
  logic [IDW-1:0]      last_q;
  logic [IDW-1:0]      grant_id_q;
  logic [DWIDTH-1:0]   fu_a_q;
  logic [DWIDTH-1:0]   fu_b_q;
  logic [DWIDTH-1:0]   resp_result_q;
  logic [NREQ-1:0]     req_ready_q;
  logic [NREQ-1:0]     resp_finish_q;
  logic                fu_valid_q;
  logic                busy_q;
  logic                err_q;

  logic                pick_any;
  logic [IDW-1:0]      pick_idx;
  logic                grant_fire;
  logic [NREQ-1:0]     pick_onehot;
  logic [NREQ-1:0]     owner_onehot;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req       (req_valid),
    .last      (last_q),
    .any       (pick_any),
    .grant_idx (pick_idx)
  );

  // A grant is taken only from idle, with a request pending and the unit free.
  always_comb begin
    grant_fire   = (state_q == S_IDLE) && pick_any && fu_ready;
    pick_onehot  = NREQ'(1) << pick_idx;
    owner_onehot = NREQ'(1) << grant_id_q;
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= IDW'(NREQ - 1);
      grant_id_q    <= '0;
      fu_a_q        <= '0;
      fu_b_q        <= '0;
      resp_result_q <= '0;
      req_ready_q   <= '0;
      resp_finish_q <= '0;
      fu_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      req_ready_q   <= '0;
      resp_finish_q <= '0;
      fu_valid_q    <= 1'b0;

      // A result with no operation in flight (e.g. one abandoned by reset) is flagged and dropped.
      if (fu_finish && (state_q != S_WAIT)) begin
        err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_fire) begin
            fu_a_q      <= req_a[pick_idx];
            fu_b_q      <= req_b[pick_idx];
            grant_id_q  <= pick_idx;
            last_q      <= pick_idx;
            req_ready_q <= pick_onehot;
            fu_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (fu_finish) begin
            resp_result_q <= fu_result;
            resp_finish_q <= owner_onehot;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_finish  = resp_finish_q;
  assign resp_result  = resp_result_q;
  assign fu_valid     = fu_valid_q;
  assign fu_a         = fu_a_q;
  assign fu_b         = fu_b_q;
  assign busy         = busy_q;
  assign grant_id     = grant_id_q;
  assign err_spurious = err_q;

`ifdef FP_OP_ARBITER_PERF_CNT_EN
  logic [NREQ-1:0][PERF_CW-1:0] perf_grants_q;
  logic [NREQ-1:0][PERF_CW-1:0] perf_grants_d;
  logic [PERF_CW-1:0]           perf_busy_q;
  logic [PERF_CW-1:0]           perf_busy_d;

  // Next counter values; each counter sticks at all-ones instead of wrapping.
  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_busy_d   = perf_busy_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_fire && (pick_idx == IDW'(i)) && (perf_grants_q[i] != '1)) begin
        perf_grants_d[i] = perf_grants_q[i] + 1'b1;
      end
    end
    if (busy_q && (perf_busy_q != '1)) begin
      perf_busy_d = perf_busy_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants_q <= '0;
      perf_busy_q   <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_busy_q   <= perf_busy_d;
    end
  end

  assign perf_grants      = perf_grants_q;
  assign perf_busy_cycles = perf_busy_q;
`endif

endmodule
